// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg -- shared definitions for the program counter / return-address stack.
//   op_e        : one-hot-free operation select produced by the PC decode
//   POP_OFS_DEF : default offset applied on a legacy external stack-pop load
//   cnt_width() : bits needed to count 0..DEPTH stack entries
// ---------------------------------------------------------------------------
package pc_pkg;

    typedef enum logic [2:0] {
        OP_INC     = 3'd0,
        OP_BRA_ABS = 3'd1,
        OP_BRA_REL = 3'd2,
        OP_CALL    = 3'd3,
        OP_RET     = 3'd4,
        OP_POPEXT  = 3'd5
    } op_e;

    localparam int POP_OFS_DEF = 2;

    // A full stack holds DEPTH entries, so the counter must reach DEPTH itself.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ras_stack.sv
// ---------------------------------------------------------------------------
// ras_stack -- circular LIFO of return addresses.
//   clk, rst   : clock, asynchronous active-low reset (pointer/count only)
//   push_i     : write data_i on top; when full the oldest entry is dropped
//   pop_i      : remove the top entry (ignored while empty)
//   data_i     : address to push
//   top_o      : current top entry (valid when !empty_o)
//   cnt_o      : number of valid entries, 0..RAS_DEPTH
//   full_o     : cnt_o == RAS_DEPTH
//   empty_o    : cnt_o == 0
// ---------------------------------------------------------------------------
module ras_stack
    import pc_pkg::*;
#(
    parameter int AW        = 16,
    parameter int RAS_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              push_i,
    input  logic                              pop_i,
    input  logic [AW-1:0]                     data_i,
    output logic [AW-1:0]                     top_o,
    output logic [cnt_width(RAS_DEPTH)-1:0]   cnt_o,
    output logic                              full_o,
    output logic                              empty_o
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = cnt_width(RAS_DEPTH);

    // wr_ptr points at the next free slot. Because the depth is a power of
    // two the pointer wraps naturally; when the stack is full it therefore
    // points at the oldest entry, which is exactly the slot a push overwrites.
    logic [AW-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic do_push, do_pop;

    assign full_o  = (cnt_q == CW'(RAS_DEPTH));
    assign empty_o = (cnt_q == '0);
    assign cnt_o   = cnt_q;
    assign top_o   = mem_q[wr_ptr_q - PW'(1)];

    // Pop takes precedence should both ever be requested together.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && !pop_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (do_pop) begin
            wr_ptr_d = wr_ptr_q - PW'(1);
            cnt_d    = cnt_q - CW'(1);
        end else if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (!full_o) cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is not reset; entries are only read once a push has made them valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/pc_ras.sv
// ---------------------------------------------------------------------------
// pc_ras -- program counter with branch, relative branch, call/return via an
// internal return-address stack, and a legacy external stack-pop load.
//   clk, rst   : clock, asynchronous active-low reset
//   en         : advance enable (0 = hold all state)
//   w          : qualifies call/ret/pop_ext/bra
//   bra, rel   : branch request; rel selects out + signed in vs. absolute in
//   call, ret  : push out+1 and jump to in / pop top into out
//   pop_ext    : out <= in + POP_OFS
//   in         : target, offset or popped value
//   out        : current PC
//   ras_cnt    : valid stack entries; ras_full / ras_empty decode it
//   ras_ovf    : sticky, push while full
//   ras_unf    : sticky, pop while empty
// Priority per edge: ret > call > pop_ext > bra > increment.
// ---------------------------------------------------------------------------
module pc_ras
    import pc_pkg::*;
#(
    parameter int AW        = 16,
    parameter int RAS_DEPTH = 8,
    parameter int POP_OFS   = POP_OFS_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic                              w,
    input  logic                              bra,
    input  logic                              rel,
    input  logic                              call,
    input  logic                              ret,
    input  logic                              pop_ext,
    input  logic [AW-1:0]                     in,
    output logic [AW-1:0]                     out,
    output logic [cnt_width(RAS_DEPTH)-1:0]   ras_cnt,
    output logic                              ras_full,
    output logic                              ras_empty,
    output logic                              ras_ovf,
    output logic                              ras_unf
);

    logic [AW-1:0] pc_q, pc_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    op_e           op;

    logic          push, pop;
    logic [AW-1:0] top;
    logic [AW-1:0] pc_inc;

    assign pc_inc = pc_q + AW'(1);

    // Strobes only count when qualified by w; otherwise the PC just advances.
    always_comb begin
        op = OP_INC;
        if (w) begin
            if (ret)          op = OP_RET;
            else if (call)    op = OP_CALL;
            else if (pop_ext) op = OP_POPEXT;
            else if (bra)     op = rel ? OP_BRA_REL : OP_BRA_ABS;
        end
    end

    assign push = en && (op == OP_CALL);
    assign pop  = en && (op == OP_RET) && !ras_empty;

    always_comb begin
        pc_d  = pc_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (en) begin
            case (op)
                OP_RET: begin
                    if (ras_empty) begin
                        pc_d  = pc_inc;
                        unf_d = 1'b1;
                    end else begin
                        pc_d  = top;
                    end
                end
                OP_CALL: begin
                    pc_d = in;
                    if (ras_full) ovf_d = 1'b1;
                end
                OP_POPEXT:  pc_d = in + AW'(POP_OFS);
                OP_BRA_ABS: pc_d = in;
                // in is already AW bits wide, so a modulo-2^AW add is the
                // same as adding its sign-extended value.
                OP_BRA_REL: pc_d = pc_q + in;
                default:    pc_d = pc_inc;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    ras_stack #(
        .AW        (AW),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (pc_inc),
        .top_o   (top),
        .cnt_o   (ras_cnt),
        .full_o  (ras_full),
        .empty_o (ras_empty)
    );

    assign out     = pc_q;
    assign ras_ovf = ovf_q;
    assign ras_unf = unf_q;

endmodule

// File: tb/tb_pc_ras.sv
module tb_pc_ras;

    localparam int AW = 16;
    localparam int RAS_DEPTH = 4;
    localparam int POP_OFS = 2;

    logic          clk = 1'b0;
    logic          rst, en, w, bra, rel, call, ret, pop_ext;
    logic [AW-1:0] in;
    logic [AW-1:0] out;
    logic [2:0]    ras_cnt;
    logic          ras_full, ras_empty, ras_ovf, ras_unf;

    int n_asrt = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pc_ras #(
        .AW        (AW),
        .RAS_DEPTH (RAS_DEPTH),
        .POP_OFS   (POP_OFS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .w         (w),
        .bra       (bra),
        .rel       (rel),
        .call      (call),
        .ret       (ret),
        .pop_ext   (pop_ext),
        .in        (in),
        .out       (out),
        .ras_cnt   (ras_cnt),
        .ras_full  (ras_full),
        .ras_empty (ras_empty),
        .ras_ovf   (ras_ovf),
        .ras_unf   (ras_unf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One rising edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        w = 0; bra = 0; rel = 0; call = 0; ret = 0; pop_ext = 0; in = '0;
    endtask

    task automatic do_call(input logic [AW-1:0] tgt);
        idle(); w = 1; call = 1; in = tgt;
        step();
    endtask

    task automatic do_ret();
        idle(); w = 1; ret = 1;
        step();
    endtask

    task automatic do_abs(input logic [AW-1:0] tgt);
        idle(); w = 1; bra = 1; in = tgt;
        step();
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; idle();

        // Reset state
        #2;
        chk("rst_out",   out,       32'h0);
        chk("rst_cnt",   ras_cnt,   32'h0);
        chk("rst_empty", ras_empty, 32'h1);
        chk("rst_full",  ras_full,  32'h0);
        chk("rst_ovf",   ras_ovf,   32'h0);
        chk("rst_unf",   ras_unf,   32'h0);
        step();
        chk("rst_hold_out", out, 32'h0);

        @(negedge clk); rst = 1'b1; en = 1'b1;
        step(); step(); step();
        chk("inc3", out, 32'h0003);

        // Unqualified branch just increments
        w = 0; bra = 1; in = 16'h1234;
        step();
        chk("w0_bra", out, 32'h0004);

        do_abs(16'h6AB3);
        chk("bra_abs", out, 32'h6AB3);

        do_abs(16'h0010);
        idle(); w = 1; bra = 1; rel = 1; in = 16'hFFFE;
        step();
        chk("bra_rel_neg", out, 32'h000E);

        do_abs(16'hFFFF);
        idle();
        step();
        chk("wrap", out, 32'h0000);

        // Stall with a pending call
        en = 0; w = 1; call = 1; in = 16'h0100;
        step(); step();
        chk("stall_out", out,     32'h0000);
        chk("stall_cnt", ras_cnt, 32'h0);
        en = 1; idle();
        step();
        chk("resume", out, 32'h0001);

        // Call / return
        do_abs(16'h0005);
        do_call(16'h0100);
        chk("call_out", out,     32'h0100);
        chk("call_cnt", ras_cnt, 32'h1);
        idle(); step(); step();
        chk("call_inc", out, 32'h0102);
        do_ret();
        chk("ret_out",   out,       32'h0006);
        chk("ret_cnt",   ras_cnt,   32'h0);
        chk("ret_empty", ras_empty, 32'h1);

        // Nested calls: A1=0007 A2=0201 A3=0301 A4=0401 A5=0501
        do_call(16'h0200);
        do_call(16'h0300);
        do_call(16'h0400);
        do_call(16'h0500);
        chk("full4_full", ras_full, 32'h1);
        chk("full4_ovf",  ras_ovf,  32'h0);
        do_call(16'h0600);
        chk("ovf_out",  out,      32'h0600);
        chk("ovf_full", ras_full, 32'h1);
        chk("ovf_flag", ras_ovf,  32'h1);
        chk("ovf_cnt",  ras_cnt,  32'h4);

        do_ret(); chk("pop_a5", out, 32'h0501);
        do_ret(); chk("pop_a4", out, 32'h0401);
        do_ret(); chk("pop_a3", out, 32'h0301);
        do_ret(); chk("pop_a2", out, 32'h0201);
        chk("pop_empty", ras_empty, 32'h1);
        do_ret();
        chk("unf_out",  out,     32'h0202);
        chk("unf_flag", ras_unf, 32'h1);
        chk("unf_cnt",  ras_cnt, 32'h0);
        chk("ovf_sticky", ras_ovf, 32'h1);

        // Reset mid-sequence clears everything immediately
        do_call(16'h0700);
        chk("pre_rst_cnt", ras_cnt, 32'h1);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_out",   out,       32'h0);
        chk("mid_rst_cnt",   ras_cnt,   32'h0);
        chk("mid_rst_empty", ras_empty, 32'h1);
        chk("mid_rst_ovf",   ras_ovf,   32'h0);
        chk("mid_rst_unf",   ras_unf,   32'h0);
        @(negedge clk); rst = 1'b1;

        // Legacy pop
        idle(); w = 1; pop_ext = 1; in = 16'h87AB;
        step();
        chk("popext_out", out,     32'h87AD);
        chk("popext_cnt", ras_cnt, 32'h0);

        // Priority: ret beats call and bra
        do_call(16'h0900);
        chk("prio_pre_cnt", ras_cnt, 32'h1);
        idle(); w = 1; ret = 1; call = 1; bra = 1; in = 16'h1111;
        step();
        chk("prio_out",   out,       32'h87AE);
        chk("prio_cnt",   ras_cnt,   32'h0);
        chk("prio_empty", ras_empty, 32'h1);
        chk("prio_ovf",   ras_ovf,   32'h0);

        idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
